// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive FIFO with overrun flag and RTS flow control
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS  = 8,
  parameter int DEPTH         = 4,
  parameter int RTS_THRESHOLD = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    rx_valid,
  input  logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_read,
  input  logic                    fifo_read,
  output logic [PAYLOAD_BITS-1:0] fifo_data,
  output logic                    fifo_valid,
  output logic [$clog2(DEPTH):0]  level,
  input  logic                    flush,
  output logic                    overrun,
  input  logic                    overrun_clear,
  output logic                    rts_n
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] RTS_L   = LW'(RTS_THRESHOLD);

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           level_next;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    we;
  logic                    drop;

  assign full       = (level == DEPTH_L);
  assign fifo_valid = (level != '0);
  assign fifo_data  = mem[rd_ptr];

  // A byte still shown during its acknowledge cycle must not be captured again.
  assign push = rx_valid & ~rx_read;
  assign pop  = fifo_read & fifo_valid;
  assign we   = push & (~full | pop) & ~flush;
  assign drop = push & full & ~pop & ~flush;

  always_comb begin
    level_next = level;
    if (flush)
      level_next = '0;
    else if (we && !pop)
      level_next = level + LW'(1);
    else if (pop && !we)
      level_next = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rx_read <= 1'b0;
      overrun <= 1'b0;
      rts_n   <= 1'b1;
    end else begin
      rx_read <= push;
      level   <= level_next;
      // Computed from the post-update level so rts_n tracks level without lag.
      rts_n   <= (level_next >= RTS_L);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (we)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop)
        overrun <= 1'b1;
      else if (overrun_clear)
        overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_ptr] <= rx_data;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - queue-model bench for uart_rx_fifo
module tb_uart_rx_fifo;
  localparam int DEPTH = 4;
  localparam int THR   = 3;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_read;
  logic       fifo_read;
  logic [7:0] fifo_data;
  logic       fifo_valid;
  logic [2:0] level;
  logic       flush;
  logic       overrun;
  logic       overrun_clear;
  logic       rts_n;

  int tests = 0;
  int fails = 0;

  uart_rx_fifo #(.PAYLOAD_BITS(8), .DEPTH(DEPTH), .RTS_THRESHOLD(THR)) dut (
    .clk(clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_read(rx_read), .fifo_read(fifo_read), .fifo_data(fifo_data),
    .fifo_valid(fifo_valid), .level(level), .flush(flush), .overrun(overrun),
    .overrun_clear(overrun_clear), .rts_n(rts_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a byte queue plus ack/overrun/rts bits, updated once per edge.
  logic [7:0] q[$];
  bit m_live = 0, m_ack = 0, m_ov = 0, m_rts = 1;
  bit m_push, m_pop, m_full;

  always @(posedge clk) begin
    if (!resetn) begin
      q.delete();
      m_ack = 0; m_ov = 0; m_rts = 1; m_live = 1;
    end else if (m_live) begin
      m_push = rx_valid && !m_ack;
      m_pop  = fifo_read && (q.size() > 0);
      m_full = (q.size() == DEPTH);
      if (m_push && m_full && !m_pop && !flush) m_ov = 1;
      else if (overrun_clear) m_ov = 0;
      if (flush) q.delete();
      else begin
        if (m_pop) void'(q.pop_front());
        if (m_push && (!m_full || m_pop)) q.push_back(rx_data);
      end
      m_ack = m_push;
      m_rts = (q.size() >= THR);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_rx_read", int'(rx_read), int'(m_ack));
      chk("m_level", int'(level), q.size());
      chk("m_fifo_valid", int'(fifo_valid), int'(q.size() != 0));
      chk("m_overrun", int'(overrun), int'(m_ov));
      chk("m_rts_n", int'(rts_n), int'(m_rts));
      if (q.size() != 0) chk("m_fifo_data", int'(fifo_data), int'(q[0]));
    end
  end

  task automatic cyc(input bit v, input logic [7:0] d, input bit rd, input bit fl, input bit clr);
    rx_valid = v; rx_data = d; fifo_read = rd; flush = fl; overrun_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1, b, 0, 0, 0);
    cyc(1, b, 0, 0, 0);
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, int'(fifo_valid), 1);
    chk(name, int'(fifo_data), int'(exp));
    cyc(0, 8'h00, 1, 0, 0);
  endtask

  bit v_r, drop_next;
  logic [7:0] d_r;
  int rd_pct;

  initial begin
    resetn = 0; rx_valid = 0; rx_data = 0; fifo_read = 0; flush = 0; overrun_clear = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(fifo_valid), 0);
    chk("rst_rts_n", int'(rts_n), 1);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_rx_read", int'(rx_read), 0);
    cyc(0, 8'h00, 0, 0, 0);
    chk("idle_rts_n", int'(rts_n), 0);

    cyc(1, 8'hA5, 0, 0, 0);
    chk("single_ack", int'(rx_read), 1);
    cyc(1, 8'hA5, 0, 0, 0);
    chk("single_ack_once", int'(rx_read), 0);
    chk("single_level", int'(level), 1);
    pop_expect("single_data", 8'hA5);
    chk("single_empty_level", int'(level), 0);
    chk("single_empty_valid", int'(fifo_valid), 0);

    send(8'h01); send(8'h02);
    chk("fill2_rts_n", int'(rts_n), 0);
    send(8'h03);
    chk("fill3_rts_n", int'(rts_n), 1);
    send(8'h04);
    chk("fill4_level", int'(level), 4);
    pop_expect("wrap_01", 8'h01); pop_expect("wrap_02", 8'h02);
    send(8'h05); send(8'h06);
    pop_expect("wrap_03", 8'h03); pop_expect("wrap_04", 8'h04);
    pop_expect("wrap_05", 8'h05); pop_expect("wrap_06", 8'h06);
    chk("wrap_level", int'(level), 0);

    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    cyc(1, 8'h55, 0, 0, 0);
    chk("ovr_ack", int'(rx_read), 1);
    chk("ovr_level", int'(level), 4);
    chk("ovr_flag", int'(overrun), 1);
    cyc(1, 8'h55, 0, 0, 0);
    pop_expect("ovr_11", 8'h11); pop_expect("ovr_22", 8'h22);
    pop_expect("ovr_33", 8'h33); pop_expect("ovr_44", 8'h44);
    cyc(0, 8'h00, 0, 0, 1);
    chk("ovr_clear", int'(overrun), 0);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    cyc(1, 8'hB5, 0, 0, 1);
    chk("ovr_set_wins", int'(overrun), 1);
    cyc(1, 8'hB5, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 1);

    cyc(1, 8'h77, 1, 0, 0);
    chk("pp_level", int'(level), 4);
    chk("pp_overrun", int'(overrun), 0);
    cyc(1, 8'h77, 0, 0, 0);
    pop_expect("pp_a2", 8'hA2); pop_expect("pp_a3", 8'hA3);
    pop_expect("pp_a4", 8'hA4); pop_expect("pp_77", 8'h77);
    cyc(0, 8'h00, 1, 0, 0);
    chk("empty_pop_level", int'(level), 0);
    chk("empty_pop_valid", int'(fifo_valid), 0);

    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    send(8'hDD);
    pop_expect("fl_c1", 8'hC1); pop_expect("fl_c2", 8'hC2);
    cyc(1, 8'h99, 0, 1, 0);
    chk("fl_ack", int'(rx_read), 1);
    chk("fl_level", int'(level), 0);
    chk("fl_valid", int'(fifo_valid), 0);
    cyc(1, 8'h99, 0, 0, 0);
    chk("fl_overrun_kept", int'(overrun), 1);
    send(8'hAB);
    pop_expect("fl_no_99", 8'hAB);
    cyc(0, 8'h00, 0, 0, 1);

    cyc(1, 8'hC3, 0, 0, 0);
    chk("rstmid_ack", int'(rx_read), 1);
    resetn = 0;
    cyc(1, 8'hC3, 0, 0, 0);
    chk("rstmid_rx_read", int'(rx_read), 0);
    chk("rstmid_level", int'(level), 0);
    resetn = 1;
    cyc(0, 8'h00, 0, 0, 0);

    v_r = 0; drop_next = 0; d_r = 0;
    for (int i = 0; i < 4000; i++) begin
      rd_pct = ((i / 500) % 2 == 0) ? 20 : 70;
      resetn = ($urandom_range(0, 399) != 0);
      if (!resetn) begin
        v_r = 0; drop_next = 0;
      end else if (rx_read) begin
        drop_next = 1;
      end else if (drop_next) begin
        v_r = 0; drop_next = 0;
      end else if (!v_r && $urandom_range(0, 1) == 1) begin
        v_r = 1; d_r = 8'($urandom);
      end
      cyc(v_r, d_r, $urandom_range(0, 99) < rd_pct,
          $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
    end
    resetn = 1;
    cyc(0, 8'h00, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver. It takes each completed byte from the receiver's valid/data outputs, acknowledges it with a one-cycle read pulse, and stores it in a small first-word-fall-through FIFO for the CPU peripheral bus. It also provides a level count, a sticky overrun flag and an active-low flow-control output derived from FIFO fill level.

Parameters:
PAYLOAD_BITS, 8, width of each received byte; must match the receiver.
DEPTH, 4, number of FIFO entries; power of two, minimum 2.
RTS_THRESHOLD, 3, level at or above which rts_n is driven high (stop sending); range 1..DEPTH.

Ports:
clk  input  1  system clock.
resetn  input  1  synchronous, active-low reset.
rx_valid  input  1  receiver holds a completed byte.
rx_data  input  PAYLOAD_BITS  receiver byte; stable while rx_valid=1.
rx_read  output  1  one-cycle acknowledge to the receiver; the receiver clears rx_valid after it.
fifo_read  input  1  CPU pop strobe.
fifo_data  output  PAYLOAD_BITS  head entry; meaningful only when fifo_valid=1.
fifo_valid  output  1  FIFO not empty.
level  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
flush  input  1  discard all entries.
overrun  output  1  sticky: a byte was dropped because the FIFO was full.
overrun_clear  input  1  clears overrun.
rts_n  output  1  active-low flow control: 0 = ready to receive.

Behaviour:
- Reset values (resetn=0 at a clk edge): rd/wr pointers 0, level 0, fifo_valid 0, rx_read 0, overrun 0, rts_n 1. Storage contents are not reset. fifo_data is don't-care while empty.
- Accept condition: push = rx_valid & ~rx_read.
  - The ~rx_read term stops a byte being captured twice. The receiver still shows valid in the cycle its acknowledge is high.
- rx_read is registered: rx_read <= push. It is high for exactly one cycle, one cycle after capture. It is never high two cycles in a row.
- Every accepted byte is acknowledged, including dropped ones. The receiver is never stalled.
- pop = fifo_read & fifo_valid. A pop while empty is ignored, with no pointer or level change.
- Write enable: we = push & (~full | pop) & ~flush.
  - When full, a push in the same cycle as a pop succeeds.
- Drop: push & full & ~pop & ~flush. A drop sets overrun at the next edge.
  - If a drop and overrun_clear occur together, the set wins.
- overrun_clear alone clears overrun at the next edge.
- Write: mem[wr_ptr] <= rx_data and wr_ptr increments.
- Pop: rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally, DEPTH-1 -> 0.
- Level update:
  - +1 on write only.
  - -1 on pop only.
  - Unchanged on simultaneous write and pop.
  - Never exceeds DEPTH and never goes below 0.
- full = (level == DEPTH); fifo_valid = (level != 0). Both are derived from the registered level.
- Read path is first-word fall-through: fifo_data = mem[rd_ptr], combinational from storage.
  - A written byte is visible on fifo_data/fifo_valid one cycle after the push cycle.
- flush: at the next edge, pointers and level go to 0 and the byte being pushed in that cycle is discarded.
  - flush has priority over push and pop.
  - rx_read still pulses for a byte pushed in the flush cycle; overrun is not set by it.
  - overrun is unaffected by flush.
- rts_n is registered: rts_n <= (level_next >= RTS_THRESHOLD), where level_next is the post-update level. This gives zero extra lag relative to level.
- Reset mid-operation: all state returns to reset values at that edge, and any in-flight acknowledge is cancelled (rx_read=0).
  - Because the receiver resets on the same resetn, there is no stale handshake.

Test Plan:
- Reset then idle -> at the first cycle after reset release: level=0, fifo_valid=0, rts_n=1, overrun=0, rx_read=0. One cycle later rts_n=0.
- Single byte: rx_valid=1 with rx_data=8'hA5, held until rx_read -> rx_read high exactly 1 cycle after capture. Then fifo_valid=1, fifo_data=8'hA5, level=1. Pop with fifo_read -> level=0, fifo_valid=0.
- Fill and wrap, DEPTH=4, RTS_THRESHOLD=3: push 8'h01..8'h04 -> rts_n=1 once level=3. Pop 2 bytes, push 8'h05 and 8'h06 (pointer wrap), then drain -> read order 03,04,05,06 and level returns to 0.
- Overrun: FIFO full with 11,22,33,44, push 8'h55 with no pop -> rx_read pulses, overrun=1, level stays 4, drain yields 11,22,33,44. overrun_clear -> overrun=0. Drop and clear in the same cycle -> overrun=1.
- Push and pop in the same cycle: at level=4 push 8'h77 with fifo_read=1 -> level stays 4, no overrun, 8'h77 emerges last. At level=0, fifo_read=1 alone -> no change.
- Flush with a simultaneous push of 8'h99 at level=2 -> level=0, fifo_valid=0, rx_read pulses, overrun unchanged, 8'h99 never appears. Assert resetn=0 mid-push -> rx_read=0 on the next cycle.
